// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO pair: 3-cycle multiply/accumulate,
// 34-cycle non-restoring divide, single-edge MTHI/MTLO.
module mdu_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDivPre,
        StDivIter,
        StDivPost
    } state_e;

    state_e      state_q;
    logic [1:0]  mul_cnt_q;
    logic [4:0]  div_cnt_q;
    logic [31:0] a_q, b_q, dvs_q;
    logic [3:0]  op_q;
    logic [64:0] pr_q;
    logic        qneg_q, rneg_q;
    logic [31:0] hi_q, lo_q;

    logic               is_div, is_mul, is_mt;
    logic signed [32:0] mul_a, mul_b;
    logic signed [65:0] mul_full;
    logic [63:0]        acc, mul_res;
    logic               sa, sb;
    logic [33:0]        r_shift, r_next;
    logic [31:0]        rem_fix, quot_out, rem_out;

    always_comb begin
        is_div   = (op[3:1] == 3'b001);
        is_mul   = !op[3] && !is_div;
        is_mt    = (op[3:1] == 3'b100);

        // op[0] selects unsigned for every mul/div flavour
        mul_a    = {~op_q[0] & a_q[31], a_q};
        mul_b    = {~op_q[0] & b_q[31], b_q};
        mul_full = mul_a * mul_b;
        acc      = {hi_q, lo_q};
        if (!op_q[2]) begin
            mul_res = mul_full[63:0];
        end else if (op_q[1]) begin
            mul_res = acc - mul_full[63:0];
        end else begin
            mul_res = acc + mul_full[63:0];
        end

        sa       = ~op_q[0] & a_q[31];
        sb       = ~op_q[0] & b_q[31];

        // Partial remainder is 33-bit signed; shifting in the next dividend bit needs 34 bits.
        r_shift  = {pr_q[64:32], pr_q[31]};
        r_next   = pr_q[64] ? r_shift + {2'b00, dvs_q} : r_shift - {2'b00, dvs_q};

        rem_fix  = pr_q[64] ? pr_q[63:32] + dvs_q : pr_q[63:32];
        quot_out = qneg_q ? -pr_q[31:0] : pr_q[31:0];
        rem_out  = rneg_q ? -rem_fix : rem_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mul_cnt_q <= 2'd0;
            div_cnt_q <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            dvs_q     <= 32'd0;
            op_q      <= 4'd0;
            pr_q      <= 65'd0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else if (abort) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_mt) begin
                            if (op[0]) lo_q <= A;
                            else       hi_q <= A;
                        end else if (is_mul || is_div) begin
                            a_q       <= A;
                            b_q       <= B;
                            op_q      <= op;
                            mul_cnt_q <= 2'd2;
                            state_q   <= is_div ? StDivPre : StMul;
                        end
                    end
                end
                StMul: begin
                    if (mul_cnt_q == 2'd0) begin
                        {hi_q, lo_q} <= mul_res;
                        state_q      <= StIdle;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - 2'd1;
                    end
                end
                StDivPre: begin
                    pr_q      <= {33'd0, (sa ? -a_q : a_q)};
                    dvs_q     <= sb ? -b_q : b_q;
                    qneg_q    <= sa ^ sb;
                    rneg_q    <= sa;
                    div_cnt_q <= 5'd31;
                    state_q   <= StDivIter;
                end
                StDivIter: begin
                    pr_q <= {r_next[32:0], pr_q[30:0], ~r_next[33]};
                    if (div_cnt_q == 5'd0) state_q <= StDivPost;
                    else                   div_cnt_q <= div_cnt_q - 5'd1;
                end
                StDivPost: begin
                    if (b_q == 32'd0) begin
                        lo_q <= 32'hFFFF_FFFF;
                        hi_q <= a_q;
                    end else begin
                        lo_q <= quot_out;
                        hi_q <= rem_out;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
